// File: rtl/snail_seq_gen.sv
// Bit-serial pattern transmitter: shifts a captured pattern out MSB-first,
// repeating it reps+1 times with GAP idle cycles between passes.
module snail_seq_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             D,
  output logic             D_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned GAP_W  = 4;
  localparam int unsigned NAME_W = 40;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sh;
  logic [WIDTH-1:0]   pat_al;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   len_q;
  logic [REP_W-1:0]   rep_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NAME_W-1:0]  state_name;

  logic [LEN_W-1:0]   len_eff_c;
  logic [WIDTH-1:0]   pat_al_c;

  // Clamp the length and left-align the pattern so bit [len-1] sits at the MSB.
  always_comb begin
    len_eff_c = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    pat_al_c  = pattern << (LEN_W'(WIDTH) - len_eff_c);
  end

  // bit_cnt holds the number of bits still to drive after the one on D.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sh      <= '0;
      pat_al  <= '0;
      bit_cnt <= '0;
      len_q   <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      D       <= 1'b0;
      D_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rep_cnt <= reps;
            len_q   <= len_eff_c;
            pat_al  <= pat_al_c;
            busy    <= 1'b1;
            if (len_eff_c == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_SHIFT;
              D       <= pat_al_c[WIDTH-1];
              D_valid <= 1'b1;
              sh      <= pat_al_c << 1;
              bit_cnt <= len_eff_c - LEN_W'(1);
            end
          end
        end

        S_SHIFT: begin
          if (bit_cnt != '0) begin
            D       <= sh[WIDTH-1];
            sh      <= sh << 1;
            bit_cnt <= bit_cnt - LEN_W'(1);
          end else if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt - REP_W'(1);
            if (GAP > 0) begin
              state   <= S_GAP;
              D       <= 1'b0;
              D_valid <= 1'b0;
              gap_cnt <= GAP_W'(GAP - 1);
            end else begin
              D       <= pat_al[WIDTH-1];
              sh      <= pat_al << 1;
              bit_cnt <= len_q - LEN_W'(1);
            end
          end else begin
            state   <= S_DONE;
            D       <= 1'b0;
            D_valid <= 1'b0;
            done    <= 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            state   <= S_SHIFT;
            D       <= pat_al[WIDTH-1];
            D_valid <= 1'b1;
            sh      <= pat_al << 1;
            bit_cnt <= len_q - LEN_W'(1);
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state   <= S_IDLE;
          D       <= 1'b0;
          D_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // ASCII state name for waveform debug.
  always_comb begin
    case (state)
      S_IDLE:  state_name = "IDLE ";
      S_SHIFT: state_name = "SHIFT";
      S_GAP:   state_name = "GAP  ";
      S_DONE:  state_name = "DONE ";
      default: state_name = "?????";
    endcase
  end

endmodule

// File: tb/tb_snail_seq_gen.sv
// Directed bench for snail_seq_gen: per-cycle transaction-level model for a
// GAP=1 and a GAP=0 instance, plus hand-computed stream/count expectations.
module tb_snail_seq_gen;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned REP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic d1, v1, b1, dn1;
  logic d0, v0, b0, dn0;

  snail_seq_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .D(d1), .D_valid(v1), .busy(b1), .done(dn1)
  );

  snail_seq_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .D(d0), .D_valid(v0), .busy(b0), .done(dn0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic v;
    logic b;
    logic dn;
  } exp_t;
  typedef exp_t exp_q_t[$];

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;
  int t0      = 0;

  exp_q_t q1, q0;

  // Expected output sequence of one accepted transfer, one entry per cycle.
  function automatic exp_q_t build(input logic [WIDTH-1:0] pat, input int l_in,
                                   input int r, input int gap);
    exp_q_t q;
    int l;
    l = (l_in > int'(WIDTH)) ? int'(WIDTH) : l_in;
    if (l > 0) begin
      for (int p = 0; p <= r; p++) begin
        for (int i = l - 1; i >= 0; i--) q.push_back('{d: pat[i], v: 1'b1, b: 1'b1, dn: 1'b0});
        if (p < r) for (int g = 0; g < gap; g++) q.push_back('{d: 1'b0, v: 1'b0, b: 1'b1, dn: 1'b0});
      end
    end
    q.push_back('{d: 1'b0, v: 1'b0, b: 1'b1, dn: 1'b1});
    return q;
  endfunction

  // Model advance: an empty queue means idle, so only then is start accepted.
  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() != 0) void'(q1.pop_front());
      else if (start) q1 = build(pattern, int'(len), int'(reps), 1);
      if (q0.size() != 0) void'(q0.pop_front());
      else if (start) q0 = build(pattern, int'(len), int'(reps), 0);
    end
  end

  logic [3:0]  got [2];
  exp_t        e   [2];
  int          vcnt[2], bcnt[2], dcnt[2], run[2], maxrun[2];
  logic [63:0] strm[2];
  logic [15:0] vseq;
  logic [2:0]  dh;
  int          det, first_v, done_at;

  always_comb begin
    got[1] = {d1, v1, b1, dn1};
    got[0] = {d0, v0, b0, dn0};
  end

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      vcnt[k] = 0; bcnt[k] = 0; dcnt[k] = 0; run[k] = 0; maxrun[k] = 0; strm[k] = '0;
    end
    vseq = '0; dh = '0; det = 0; first_v = -1; done_at = -1;
  endtask

  // Per-cycle compare against the model, then accumulate stream statistics.
  always @(negedge clk) begin
    if (chk_en) begin
      cyc++;
      e[1] = (q1.size() != 0) ? q1[0] : exp_t'('0);
      e[0] = (q0.size() != 0) ? q0[0] : exp_t'('0);
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (got[k] !== 4'(e[k])) begin
          errors++;
          $display("FAIL model_gap%0d cyc %0d: got D/valid/busy/done=%b required %b",
                   (k == 1) ? 1 : 0, cyc, got[k], 4'(e[k]));
        end
        if (got[k][1]) bcnt[k]++;
        if (got[k][0]) dcnt[k]++;
        if (got[k][2]) begin
          vcnt[k]++;
          run[k]++;
          strm[k] = {strm[k][62:0], got[k][3]};
          if (run[k] > maxrun[k]) maxrun[k] = run[k];
        end else begin
          run[k] = 0;
        end
      end
      if (b1) vseq = {vseq[14:0], v1};
      dh = {dh[1:0], d1};
      if (dh == 3'b110) det++;
      if (v1 && first_v < 0) first_v = cyc - t0;
      if (dn1) done_at = cyc - t0;
    end
  end

  task automatic check(input string name, input logic [63:0] g, input logic [63:0] x);
    vectors++;
    if (g !== x) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, g, x);
    end
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                             input logic [REP_W-1:0] r);
    clear_stats();
    @(posedge clk); #1;
    pattern = p; len = l; reps = r; start = 1'b1;
    @(posedge clk);
    t0 = cyc;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("timeout", 64'(n), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0;
    clear_stats();
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({d1, v1, b1, dn1, d0, v0, b0, dn0}), 64'(0));
    check("reset_state_name", 64'(u_dut.state_name), 64'("IDLE "));

    // Basic 110 burst.
    pulse_start(8'b0000_0110, 4'd3, 4'd0);
    wait_done(50);
    check("t1_stream", strm[1], 64'b110);
    check("t1_valid_cnt", 64'(vcnt[1]), 64'd3);
    check("t1_busy_cnt", 64'(bcnt[1]), 64'd4);
    check("t1_done_cnt", 64'(dcnt[1]), 64'd1);
    check("t1_latency", 64'(first_v), 64'd1);
    check("t1_done_at", 64'(done_at), 64'd4);
    check("t1_det110", 64'(det), 64'd1);

    // Repeats with gaps.
    pulse_start(8'b0000_0110, 4'd3, 4'd2);
    wait_done(50);
    check("t2_valid_seq", 64'(vseq[11:0]), 64'b1110_1110_1110);
    check("t2_stream", strm[1], 64'b110_110_110);
    check("t2_busy_cnt", 64'(bcnt[1]), 64'd12);
    check("t2_done_cnt", 64'(dcnt[1]), 64'd1);
    check("t2_busy_cnt_gap0", 64'(bcnt[0]), 64'd10);
    check("t2_maxrun_gap0", 64'(maxrun[0]), 64'd9);

    // Zero length.
    pulse_start(8'hFF, 4'd0, 4'd3);
    wait_done(20);
    check("t3_valid_cnt", 64'(vcnt[1]), 64'd0);
    check("t3_busy_cnt", 64'(bcnt[1]), 64'd1);
    check("t3_done_at", 64'(done_at), 64'd1);

    // Start re-pulsed during the 2nd bit is ignored.
    pulse_start(8'hA5, 4'd8, 4'd0);
    @(posedge clk); #1;
    pattern = 8'hFF; len = 4'd2; reps = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(50);
    check("t4_stream", strm[1], 64'hA5);
    check("t4_done_cnt", 64'(dcnt[1]), 64'd1);
    check("t4_busy_cnt", 64'(bcnt[1]), 64'd9);

    // Reset on the 4th bit aborts without a done pulse.
    pulse_start(8'hA5, 4'd8, 4'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_after_rst", 64'({d1, v1, b1, dn1}), 64'(0));
    repeat (12) @(posedge clk);
    #1;
    check("t5_done_cnt", 64'(dcnt[1]), 64'd0);
    check("t5_valid_cnt", 64'(vcnt[1]), 64'd4);
    pulse_start(8'b0000_0110, 4'd3, 4'd0);
    wait_done(50);
    check("t5_fresh_stream", strm[1], 64'b110);
    check("t5_fresh_done", 64'(dcnt[1]), 64'd1);

    // Full width, all ones, maximum repeat count.
    pulse_start(8'hFF, 4'd8, 4'd15);
    wait_done(400);
    check("t6_valid_gap0", 64'(vcnt[0]), 64'd128);
    check("t6_maxrun_gap0", 64'(maxrun[0]), 64'd128);
    check("t6_busy_gap0", 64'(bcnt[0]), 64'd129);
    check("t6_valid_gap1", 64'(vcnt[1]), 64'd128);
    check("t6_maxrun_gap1", 64'(maxrun[1]), 64'd8);
    check("t6_busy_gap1", 64'(bcnt[1]), 64'd144);
    check("t6_done_gap1", 64'(dcnt[1]), 64'd1);

    // Oversized length clamps to WIDTH.
    pulse_start(8'h96, 4'd12, 4'd0);
    wait_done(50);
    check("t7_stream", strm[1], 64'h96);
    check("t7_valid_cnt", 64'(vcnt[1]), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
